// File: rtl/ahb_arbiter.sv
// Central AHB bus arbiter: round-robin grant with fixed-burst and locked-transfer
// holds, SPLIT masking with HSPLIT resume, and registered address-phase handover.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = 4
) (
    input  logic                   HCLK,
    input  logic                   HRESETN,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    input  logic [NUM_MASTERS-1:0] HSPLIT,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [1:0] TRANS_NONSEQ = 2'd2;
    localparam logic [1:0] TRANS_SEQ    = 2'd3;
    localparam logic [1:0] RESP_OKAY    = 2'd0;
    localparam logic [1:0] RESP_SPLIT   = 2'd3;

    localparam logic [NUM_MASTERS-1:0] DEFAULT_OH =
        {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
    localparam logic [MW-1:0] DEFAULT_IDX = MW'(DEFAULT_MASTER);

    // Beats remaining after the NONSEQ beat; undefined-length INCR is never held.
    function automatic logic [3:0] burst_beats_m1(input logic [2:0] burst);
        logic [3:0] beats;
        case (burst)
            3'd2, 3'd3: beats = 4'd3;
            3'd4, 3'd5: beats = 4'd7;
            3'd6, 3'd7: beats = 4'd15;
            default:    beats = 4'd0;
        endcase
        return beats;
    endfunction

    logic [NUM_MASTERS-1:0] hgrant_r;
    logic [NUM_MASTERS-1:0] split_mask_r;
    logic [MW-1:0]          gnt_idx_r;
    logic [MW-1:0]          rr_ptr_r;
    logic [MW-1:0]          hmaster_r;
    logic                   hmastlock_r;
    logic [3:0]             beats_left_r;

    logic [NUM_MASTERS-1:0] eligible_s;
    logic [NUM_MASTERS-1:0] shifted_s;
    logic [NUM_MASTERS-1:0] grant_oh_s;
    logic [NUM_MASTERS-1:0] split_set_s;
    logic [MW:0]            rot_s;
    logic [MW-1:0]          sel_idx_s;
    logic                   sel_found_s;
    logic                   take_s;
    logic                   resp_first_s;
    logic                   resp_second_s;
    logic                   lock_hold_s;
    logic                   hold_s;

    assign HGRANT    = hgrant_r;
    assign HMASTER   = hmaster_r;
    assign HMASTLOCK = hmastlock_r;

    // Hold and error-response qualification for the current cycle.
    always_comb begin
        eligible_s    = HBUSREQ & ~split_mask_r;
        resp_first_s  = (HREADY == 1'b0) && (HRESP != RESP_OKAY);
        resp_second_s = (HREADY == 1'b1) && (HRESP != RESP_OKAY);
        lock_hold_s   = |(hgrant_r & HLOCK & HBUSREQ);
        hold_s        = ((beats_left_r > 4'd1) || lock_hold_s) && !resp_second_s;
    end

    // Round-robin search starting after rr_ptr and wrapping back onto rr_ptr.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = DEFAULT_IDX;
        rot_s       = '0;
        shifted_s   = '0;
        take_s      = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            rot_s       = {1'b0, rr_ptr_r} + (MW+1)'(k);
            rot_s       = (rot_s >= (MW+1)'(NUM_MASTERS)) ? rot_s - (MW+1)'(NUM_MASTERS) : rot_s;
            shifted_s   = eligible_s >> rot_s;
            take_s      = !sel_found_s && shifted_s[0];
            sel_idx_s   = take_s ? MW'(rot_s) : sel_idx_s;
            sel_found_s = sel_found_s | take_s;
        end
    end

    // One-hot decodes of the selected master and of the SPLIT target.
    always_comb begin
        grant_oh_s  = '0;
        split_set_s = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            grant_oh_s[i]  = (sel_idx_s == MW'(i));
            split_set_s[i] = resp_first_s && (HRESP == RESP_SPLIT) && (hmaster_r == MW'(i));
        end
    end

    // Grant register and round-robin pointer.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            hgrant_r  <= DEFAULT_OH;
            gnt_idx_r <= DEFAULT_IDX;
            rr_ptr_r  <= DEFAULT_IDX;
        end else if (HREADY && !hold_s) begin
            hgrant_r  <= grant_oh_s;
            gnt_idx_r <= sel_idx_s;
            if (sel_found_s) begin
                rr_ptr_r <= sel_idx_s;
            end
        end
    end

    // Address-phase handover: HMASTER follows the grant one ready cycle later.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            hmaster_r   <= DEFAULT_IDX;
            hmastlock_r <= 1'b0;
        end else if (HREADY) begin
            hmaster_r   <= gnt_idx_r;
            hmastlock_r <= |(hgrant_r & HLOCK);
        end
    end

    // SPLIT mask: a set from this cycle's SPLIT wins over a same-bit HSPLIT clear.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            split_mask_r <= '0;
        end else begin
            split_mask_r <= (split_mask_r & ~HSPLIT) | split_set_s;
        end
    end

    // Fixed-length burst beat counter.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            beats_left_r <= 4'd0;
        end else if (resp_first_s) begin
            beats_left_r <= 4'd0;
        end else if (HREADY) begin
            case (HTRANS)
                TRANS_NONSEQ: beats_left_r <= burst_beats_m1(HBURST);
                TRANS_SEQ:    beats_left_r <= (beats_left_r != 4'd0) ? beats_left_r - 4'd1 : 4'd0;
                default:      beats_left_r <= beats_left_r;
            endcase
        end
    end

endmodule
